cpu_v1: RTL and testbench

Single-cycle 8-bit datapath core: 4-bit opcode decode ROM, 16x8 register file (two async read ports, one sync write port) and an 8-bit control-word ALU.
Each rising clk edge executes the 16-bit instruction on `inst`, writing the ALU result or an immediate into the destination register.
Instruction fetch and PC sit upstream; `inst` is driven by the fetch stage or the bench and held stable across each edge.

---
 rtl/cpu_v1_pkg.sv | 88 ++++++++
 rtl/cpu_v1_alu.sv | 40 ++++
 rtl/cpu_v1.sv | 61 ++++++
 tb/tb_cpu_v1.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/cpu_v1_pkg.sv
// Shared types for the cpu_v1 core: opcodes, ALU control word, flag indices
// and the opcode decode ROM.
package cpu_v1_pkg;

  localparam int NREGS = 16;
  localparam int XLEN  = 8;

  localparam int FLAG_C = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [3:0] {
    OP_ADD = 4'h0,
    OP_SUB = 4'h1,
    OP_AND = 4'h2,
    OP_OR  = 4'h3,
    OP_XOR = 4'h4,
    OP_NOT = 4'h5,
    OP_INC = 4'h6,
    OP_DEC = 4'h7,
    OP_MOV = 4'h8,
    OP_NEG = 4'h9,
    OP_LDI = 4'hF
  } opcode_e;

  localparam logic [1:0] FN_ADD = 2'b00;
  localparam logic [1:0] FN_AND = 2'b01;
  localparam logic [1:0] FN_OR  = 2'b10;
  localparam logic [1:0] FN_XOR = 2'b11;

  typedef struct packed {
    logic       za;
    logic       na;
    logic       zb;
    logic       nb;
    logic       cin;
    logic [1:0] fn;
    logic       no;
  } cw_t;

  typedef struct packed {
    cw_t  cw;
    logic we;
    logic ldi;
    logic fl_en;
  } ctrl_t;

  function automatic cw_t mk_cw(logic za, logic na, logic zb, logic nb,
                                logic cin, logic [1:0] fn, logic no);
    cw_t c;
    c.za  = za;
    c.na  = na;
    c.zb  = zb;
    c.nb  = nb;
    c.cin = cin;
    c.fn  = fn;
    c.no  = no;
    return c;
  endfunction

  // Reserved opcodes A-E decode to all-zero: no write, flags held.
  function automatic ctrl_t decode(logic [3:0] op);
    ctrl_t c;
    c = '0;
    c.we    = 1'b1;
    c.fl_en = 1'b1;
    case (opcode_e'(op))
      OP_ADD:  c.cw = mk_cw(0, 0, 0, 0, 0, FN_ADD, 0);
      OP_SUB:  c.cw = mk_cw(0, 0, 0, 1, 1, FN_ADD, 0);
      OP_AND:  c.cw = mk_cw(0, 0, 0, 0, 0, FN_AND, 0);
      OP_OR:   c.cw = mk_cw(0, 0, 0, 0, 0, FN_OR,  0);
      OP_XOR:  c.cw = mk_cw(0, 0, 0, 0, 0, FN_XOR, 0);
      OP_NOT:  c.cw = mk_cw(0, 1, 1, 0, 0, FN_OR,  0);
      OP_INC:  c.cw = mk_cw(0, 0, 1, 0, 1, FN_ADD, 0);
      OP_DEC:  c.cw = mk_cw(0, 0, 1, 1, 0, FN_ADD, 0);
      OP_MOV:  c.cw = mk_cw(0, 0, 1, 0, 0, FN_OR,  0);
      OP_NEG:  c.cw = mk_cw(0, 1, 1, 0, 1, FN_ADD, 0);
      OP_LDI: begin
        c.cw    = '0;
        c.ldi   = 1'b1;
        c.fl_en = 1'b0;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cpu_v1_alu.sv
// Combinational control-word ALU: operand zero/invert, add or bitwise op,
// optional output invert, plus carry/zero/negative status.
module cpu_v1_alu
  import cpu_v1_pkg::*;
(
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  cw_t             cw_i,
  output logic [XLEN-1:0] result_o,
  output logic            carry_o,
  output logic            zero_o,
  output logic            neg_o
);

  logic [XLEN-1:0] a_z, b_z, a_p, b_p, r_raw;
  logic [XLEN:0]   sum;

  always_comb begin
    a_z   = cw_i.za ? '0 : a_i;
    a_p   = cw_i.na ? ~a_z : a_z;
    b_z   = cw_i.zb ? '0 : b_i;
    b_p   = cw_i.nb ? ~b_z : b_z;
    sum   = {1'b0, a_p} + {1'b0, b_p} + {{XLEN{1'b0}}, cw_i.cin};
    r_raw = sum[XLEN-1:0];
    carry_o = 1'b0;
    case (cw_i.fn)
      FN_ADD: begin
        r_raw   = sum[XLEN-1:0];
        carry_o = sum[XLEN];
      end
      FN_AND:  r_raw = a_p & b_p;
      FN_OR:   r_raw = a_p | b_p;
      default: r_raw = a_p ^ b_p;
    endcase
    result_o = cw_i.no ? ~r_raw : r_raw;
    zero_o   = (result_o == '0);
    neg_o    = result_o[XLEN-1];
  end

endmodule

// File: rtl/cpu_v1.sv
// Single-cycle 8-bit core: decode ROM, 16x8 register file with two async
// read ports and one sync write port, ALU and registered flags.
module cpu_v1
  import cpu_v1_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] inst,
  input  logic [3:0]  dbg_addr,
  output logic [7:0]  dbg_data,
  output logic [7:0]  alu_out,
  output logic [2:0]  flags
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [2:0]      flags_q, flags_d;
  logic [XLEN-1:0] wr_data_d;
  logic [3:0]      op, rd, rs1, rs2;
  ctrl_t           ctl;
  logic            carry, zero, neg;

  assign op  = inst[15:12];
  assign rd  = inst[11:8];
  assign rs1 = inst[7:4];
  assign rs2 = inst[3:0];
  assign ctl = decode(op);

  cpu_v1_alu u_alu (
    .a_i      (regs_q[rs1]),
    .b_i      (regs_q[rs2]),
    .cw_i     (ctl.cw),
    .result_o (alu_out),
    .carry_o  (carry),
    .zero_o   (zero),
    .neg_o    (neg)
  );

  always_comb begin
    wr_data_d = ctl.ldi ? inst[7:0] : alu_out;
    flags_d   = flags_q;
    if (ctl.fl_en) begin
      flags_d[FLAG_C] = carry;
      flags_d[FLAG_Z] = zero;
      flags_d[FLAG_N] = neg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      flags_q <= '0;
    end else begin
      if (ctl.we) regs_q[rd] <= wr_data_d;
      flags_q <= flags_d;
    end
  end

  assign dbg_data = regs_q[dbg_addr];
  assign flags    = flags_q;

endmodule

// File: tb/tb_cpu_v1.sv
// Bench for cpu_v1: directed test-plan sequence plus random instructions,
// compared every cycle against an arithmetic reference model.
module tb_cpu_v1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] inst = 16'hA000;
  logic [3:0]  dbg_addr = 4'h0;
  logic [7:0]  dbg_data, alu_out;
  logic [2:0]  flags;

  int vectors = 0;
  int errors  = 0;
  bit run     = 1'b0;

  logic [7:0] m_regs [16];
  logic [2:0] m_flags;

  cpu_v1 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .inst     (inst),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .alu_out  (alu_out),
    .flags    (flags)
  );

  always #20 clk = ~clk;

  // Returns {carry, result} for opcodes 0-9, from plain integer arithmetic.
  function automatic logic [8:0] model_alu(input logic [15:0] i);
    int a, b, s;
    a = int'(m_regs[i[7:4]]);
    b = int'(m_regs[i[3:0]]);
    case (i[15:12])
      4'h0: s = a + b;
      4'h1: s = a + (255 - b) + 1;
      4'h2: s = a & b;
      4'h3: s = a | b;
      4'h4: s = a ^ b;
      4'h5: s = 255 - a;
      4'h6: s = a + 1;
      4'h7: s = a + 255;
      4'h8: s = a;
      4'h9: s = (255 - a) + 1;
      default: s = 0;
    endcase
    return s[8:0];
  endfunction

  function automatic void model_exec(input logic [15:0] i);
    logic [8:0] r;
    r = model_alu(i);
    if (i[15:12] <= 4'h9) begin
      m_regs[i[11:8]] = r[7:0];
      m_flags = {r[8], r[7:0] == 8'h00, r[7]};
    end else if (i[15:12] == 4'hF) begin
      m_regs[i[11:8]] = i[7:0];
    end
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 16; k++) m_regs[k] = 8'h00;
    m_flags = 3'b000;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run && rst_n) begin
      logic [8:0] r;
      chk("dbg_data", dbg_data, m_regs[dbg_addr]);
      chk("flags", {5'b0, flags}, {5'b0, m_flags});
      if (inst[15:12] <= 4'h9) begin
        r = model_alu(inst);
        chk("alu_out", alu_out, r[7:0]);
      end
    end
  end

  task automatic exec(input logic [15:0] i);
    inst = i;
    dbg_addr = 4'($urandom);
    @(posedge clk);
    if (rst_n) model_exec(i);
    #1;
  endtask

  task automatic expect_reg(input logic [3:0] idx, input logic [7:0] v);
    dbg_addr = idx;
    #1;
    chk("dbg_lit", dbg_data, v);
    chk("model_lit", m_regs[idx], v);
  endtask

  task automatic expect_flags(input logic [2:0] f);
    chk("flags_lit", {5'b0, flags}, {5'b0, f});
    chk("mflags_lit", {5'b0, m_flags}, {5'b0, f});
  endtask

  initial begin
    model_reset();
    #3;
    for (int k = 0; k < 16; k++) begin
      dbg_addr = 4'(k);
      #1;
      chk("reset_reg", dbg_data, 8'h00);
    end
    chk("reset_flags", {5'b0, flags}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    run = 1'b1;

    exec(16'hF00A); expect_reg(0, 8'd10);
    exec(16'hF102); expect_reg(1, 8'd2); expect_flags(3'b000);

    exec(16'h0001); expect_reg(0, 8'd12);
    exec(16'hF103); expect_reg(1, 8'd3);
    exec(16'h1001); expect_reg(0, 8'd9); expect_flags(3'b100);

    exec(16'hF2FF);
    exec(16'hF301);
    exec(16'h0423); expect_reg(4, 8'h00); expect_flags(3'b110);
    exec(16'h1532); expect_reg(5, 8'h02); expect_flags(3'b000);

    exec(16'hF6F0);
    exec(16'hF73C);
    exec(16'h2867); expect_reg(8, 8'h30); expect_flags(3'b000);
    exec(16'h3967); expect_reg(9, 8'hFC); expect_flags(3'b001);
    exec(16'h4A67); expect_reg(10, 8'hCC); expect_flags(3'b001);

    exec(16'h5B70); expect_reg(11, 8'hC3); expect_flags(3'b001);
    exec(16'h6C20); expect_reg(12, 8'h00); expect_flags(3'b110);
    exec(16'h9D30); expect_reg(13, 8'hFF); expect_flags(3'b001);
    exec(16'hB123); expect_reg(1, 8'h03); expect_flags(3'b001);

    // Asynchronous reset between edges, then recovery with an LDI.
    #3;
    rst_n = 1'b0;
    model_reset();
    expect_reg(0, 8'h00);
    expect_reg(13, 8'h00);
    expect_flags(3'b000);
    #2;
    rst_n = 1'b1;
    exec(16'hFE55); expect_reg(14, 8'h55); expect_flags(3'b000);

    for (int n = 0; n < 400; n++) begin
      logic [15:0] r;
      r = 16'($urandom);
      if (n < 40) r[15:12] = 4'hF;
      exec(r);
    end

    @(negedge clk);
    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
